// File: rtl/shreg_piso_reader_if.sv
// -----------------------------------------------------------------------------
// shreg_piso_reader_if
//   Bundles the load-side and drain-side handshakes of shreg_piso_reader.
//   Ports (signals):
//     load_valid  source -> reader   frame offered on load_data
//     load_ready  reader -> source   frame accepted when load_valid & load_ready
//     load_data   source -> reader   WIDTH*DEPTH frame, word k at [k*WIDTH +: WIDTH]
//     q           reader -> sink     current serial word (registered)
//     q_valid     reader -> sink     q holds a valid word
//     q_ready     sink   -> reader   word taken when q_valid & q_ready
//     q_last      reader -> sink     q is the final word of the frame
//   Modports: slave = the reader itself, master = the environment driving it.
// -----------------------------------------------------------------------------
interface shreg_piso_reader_if #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) ();
    logic                     load_valid;
    logic                     load_ready;
    logic [WIDTH*DEPTH-1:0]   load_data;
    logic [WIDTH-1:0]         q;
    logic                     q_valid;
    logic                     q_ready;
    logic                     q_last;

    modport slave (
        input  load_valid, load_data, q_ready,
        output load_ready, q, q_valid, q_last
    );

    modport master (
        output load_valid, load_data, q_ready,
        input  load_ready, q, q_valid, q_last
    );
endinterface

// File: rtl/shreg_piso_reader.sv
// -----------------------------------------------------------------------------
// shreg_piso_reader
//   Parallel-in / serial-out drain for a WIDTH x DEPTH shift chain. A whole
//   frame is captured on one load handshake and emitted word 0 first, one word
//   per q transfer. A new frame may be loaded on the cycle the last word of the
//   current frame is taken, so back-to-back frames stream without a bubble.
//   Ports:
//     clk  rising-edge clock
//     r    asynchronous active-high reset, clears every flop immediately
//     bus  shreg_piso_reader_if.slave (load and q handshakes)
// -----------------------------------------------------------------------------
module shreg_piso_reader #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  r,
    shreg_piso_reader_if.slave    bus
);
    localparam int CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  stage_q [DEPTH];
    logic [WIDTH-1:0]  stage_d [DEPTH];

    logic at_last;
    logic transfer;
    logic load_fire;

    assign at_last   = (cnt_q == CNT_LAST);
    assign transfer  = (state_q == SHIFT) && bus.q_ready;
    assign load_fire = bus.load_valid && bus.load_ready;

    // ---------------------------------------------------------------- state reg
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours; blocking here would let
    // the shift chain collapse within a single edge.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------- next state
    // NOTE: every always_comb output gets a default on entry, otherwise a
    // path that skips the assignment infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (bus.load_valid) state_d = SHIFT;
            SHIFT: if (transfer && at_last && !bus.load_valid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // load_ready looks at q_ready but never at load_valid, so the source can
    // safely make load_valid depend on load_ready.
    always_comb begin
        bus.load_ready = 1'b0;
        bus.q_valid    = 1'b0;
        bus.q_last     = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.load_ready = 1'b1;
            end
            SHIFT: begin
                bus.q_valid    = 1'b1;
                bus.q_last     = at_last;
                bus.load_ready = at_last && bus.q_ready;
            end
            default: ;
        endcase
    end

    // Stage 0 is a flop, so q is registered and load_data never reaches it
    // combinationally. Idle stages are always zero, which makes q=0 in IDLE.
    assign bus.q = stage_q[0];

    // ------------------------------------------------------------- datapath
    always_comb begin
        cnt_d   = cnt_q;
        stage_d = stage_q;
        if (load_fire) begin
            cnt_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_d[k] = bus.load_data[k*WIDTH +: WIDTH];
            end
        end else if (transfer) begin
            if (at_last) begin
                // Frame drained with nothing queued: flush to the idle image.
                cnt_d = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    stage_d[k] = '0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                for (int k = 0; k < DEPTH - 1; k++) begin
                    stage_d[k] = stage_q[k+1];
                end
                stage_d[DEPTH-1] = '0;
            end
        end
    end

    // NOTE: the stage array is reset on purpose even though it is storage:
    // the asynchronous clear both meets the reset contract and stops the
    // chain from being packed into shift-register LUTs, keeping it in FDCEs.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                stage_q[k] <= '0;
            end
        end else begin
            cnt_q   <= cnt_d;
            stage_q <= stage_d;
        end
    end
endmodule

// File: tb/tb_shreg_piso_reader.sv
// -----------------------------------------------------------------------------
// tb_shreg_piso_reader
//   Directed bench: one 4x4 reader and one 8x1 reader share clk and r.
//   Inputs change 1 ns after a rising edge; outputs are checked after that,
//   well away from the next edge.
// -----------------------------------------------------------------------------
module tb_shreg_piso_reader;
    logic clk = 1'b0;
    logic r   = 1'b1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shreg_piso_reader_if #(.WIDTH(4), .DEPTH(4)) bus_a ();
    shreg_piso_reader_if #(.WIDTH(8), .DEPTH(1)) bus_b ();

    shreg_piso_reader #(.WIDTH(4), .DEPTH(4)) dut_a (
        .clk (clk),
        .r   (r),
        .bus (bus_a)
    );

    shreg_piso_reader #(.WIDTH(8), .DEPTH(1)) dut_b (
        .clk (clk),
        .r   (r),
        .bus (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks the whole observable state of reader A in one call.
    task automatic check_a(input string tag, input logic [3:0] q, input logic v,
                           input logic last, input logic rdy);
        check({tag, ".q"},          32'(bus_a.q),          32'(q));
        check({tag, ".q_valid"},    32'(bus_a.q_valid),    32'(v));
        check({tag, ".q_last"},     32'(bus_a.q_last),     32'(last));
        check({tag, ".load_ready"}, 32'(bus_a.load_ready), 32'(rdy));
    endtask

    task automatic check_b(input string tag, input logic [7:0] q, input logic v,
                           input logic last, input logic rdy);
        check({tag, ".q"},          32'(bus_b.q),          32'(q));
        check({tag, ".q_valid"},    32'(bus_b.q_valid),    32'(v));
        check({tag, ".q_last"},     32'(bus_b.q_last),     32'(last));
        check({tag, ".load_ready"}, 32'(bus_b.load_ready), 32'(rdy));
    endtask

    initial begin
        bus_a.load_valid = 1'b0;
        bus_a.load_data  = '0;
        bus_a.q_ready    = 1'b1;
        bus_b.load_valid = 1'b0;
        bus_b.load_data  = '0;
        bus_b.q_ready    = 1'b1;

        // ---------------- reset
        #12;
        check_a("rst_a", 4'h0, 1'b0, 1'b0, 1'b1);
        check_b("rst_b", 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        r = 1'b0;

        // ---------------- 1: single frame, free-running sink
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = 16'h4321;
        tick();
        bus_a.load_valid = 1'b0;
        #1;
        check_a("t1_w0", 4'h1, 1'b1, 1'b0, 1'b0);
        tick(); check_a("t1_w1", 4'h2, 1'b1, 1'b0, 1'b0);
        tick(); check_a("t1_w2", 4'h3, 1'b1, 1'b0, 1'b0);
        tick(); check_a("t1_w3", 4'h4, 1'b1, 1'b1, 1'b1);
        tick(); check_a("t1_idle", 4'h0, 1'b0, 1'b0, 1'b1);

        // ---------------- 2: stall on word 2
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = 16'h4321;
        tick();
        bus_a.load_valid = 1'b0;
        tick(); check_a("t2_pre", 4'h2, 1'b1, 1'b0, 1'b0);
        bus_a.q_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_a("t2_stall", 4'h2, 1'b1, 1'b0, 1'b0);
            check("t2_stall.cnt", 32'(dut_a.cnt_q), 32'd1);
        end
        bus_a.q_ready = 1'b1;
        tick(); check_a("t2_w2", 4'h3, 1'b1, 1'b0, 1'b0);
        tick(); check_a("t2_w3", 4'h4, 1'b1, 1'b1, 1'b1);
        // Last word with the sink stalled: load_ready must follow q_ready.
        bus_a.q_ready = 1'b0;
        #1; check_a("t2_last_stall", 4'h4, 1'b1, 1'b1, 1'b0);
        bus_a.q_ready = 1'b1;
        tick(); check_a("t2_idle", 4'h0, 1'b0, 1'b0, 1'b1);

        // ---------------- 3: back-to-back frames, next frame held early
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = 16'h4321;
        tick();
        bus_a.load_data  = 16'h8765;
        #1;
        check_a("t3_w0", 4'h1, 1'b1, 1'b0, 1'b0);
        tick(); check_a("t3_w1", 4'h2, 1'b1, 1'b0, 1'b0);
        tick(); check_a("t3_w2", 4'h3, 1'b1, 1'b0, 1'b0);
        tick(); check_a("t3_w3", 4'h4, 1'b1, 1'b1, 1'b1);
        tick();
        bus_a.load_valid = 1'b0;
        #1;
        check_a("t3_w4", 4'h5, 1'b1, 1'b0, 1'b0);
        tick(); check_a("t3_w5", 4'h6, 1'b1, 1'b0, 1'b0);
        tick(); check_a("t3_w6", 4'h7, 1'b1, 1'b0, 1'b0);
        tick(); check_a("t3_w7", 4'h8, 1'b1, 1'b1, 1'b1);
        tick(); check_a("t3_idle", 4'h0, 1'b0, 1'b0, 1'b1);

        // ---------------- 4: asynchronous reset mid-frame
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = 16'h4321;
        tick();
        bus_a.load_valid = 1'b0;
        tick();
        tick(); check_a("t4_pre", 4'h3, 1'b1, 1'b0, 1'b0);
        #2;
        r = 1'b1;
        #1;
        check_a("t4_async", 4'h0, 1'b0, 1'b0, 1'b1);
        check("t4_async.cnt", 32'(dut_a.cnt_q), 32'd0);
        tick();
        r = 1'b0;
        bus_a.load_valid = 1'b1;
        bus_a.load_data  = 16'h0009;
        tick();
        bus_a.load_valid = 1'b0;
        #1;
        check_a("t4_w0", 4'h9, 1'b1, 1'b0, 1'b0);
        tick(); check_a("t4_w1", 4'h0, 1'b1, 1'b0, 1'b0);
        tick(); check_a("t4_w2", 4'h0, 1'b1, 1'b0, 1'b0);
        tick(); check_a("t4_w3", 4'h0, 1'b1, 1'b1, 1'b1);
        tick(); check_a("t4_idle", 4'h0, 1'b0, 1'b0, 1'b1);

        // ---------------- 5: DEPTH=1 back-to-back
        bus_b.load_valid = 1'b1;
        bus_b.load_data  = 8'hA5;
        #1; check_b("t5_idle", 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        bus_b.load_data = 8'h3C;
        #1; check_b("t5_w0", 8'hA5, 1'b1, 1'b1, 1'b1);
        tick();
        bus_b.load_valid = 1'b0;
        #1; check_b("t5_w1", 8'h3C, 1'b1, 1'b1, 1'b1);
        tick(); check_b("t5_end", 8'h00, 1'b0, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
